// File: rtl/timer_pkg.sv
// timer_pkg: run-mode codes and FSM state encoding shared by the timer files
package timer_pkg;
  localparam logic [1:0] MODE_FREE    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_AUTO    = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock, pulsing tick every (div+1) enabled cycles
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               run,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  assign tick = run && cnt_q == div;
  // count while running, restart on tick or clear, hold otherwise
  always_comb cnt_d = clr ? '0 : !run ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  // phase register
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/timer_param.sv
// timer_param: prescaled compare timer with free-run, one-shot and auto-reload modes
module timer_param
  import timer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               t_en,
  input  logic               t_clr,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic [WIDTH-1:0]   t_out,
  output logic               t_valid,
  output logic               t_busy,
  output logic               t_ovf
);
  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   cmp_q, cmp_d, out_q, out_d;
  logic               valid_q, valid_d, busy_q, busy_d, ovf_q, ovf_d;
  logic               run, start, tick, match;
  // PAUSE with t_en high counts on the same edge it resumes, so a pause costs exactly its length
  assign run   = (state_q == ST_RUN || state_q == ST_PAUSE) && t_en && !t_clr;
  assign start = state_q == ST_IDLE && t_en && !t_clr;
  assign match = out_q == cmp_q;
  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clock(clock),
    .reset(reset),
    .clr  (t_clr | start),
    .run  (run),
    .div  (presc_q),
    .tick (tick)
  );
  // next-state, counter, compare and flag logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    if (t_clr) begin
      state_d = ST_IDLE;
      out_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (t_en) begin
          state_d = ST_RUN;
          mode_d  = (mode == MODE_FREE || mode == MODE_AUTO) ? mode : MODE_ONESHOT;
          presc_d = prescale;
          cmp_d   = cmp_val;
          out_d   = '0;
        end
        ST_RUN, ST_PAUSE: if (!t_en) state_d = ST_PAUSE;
        else begin
          state_d = ST_RUN;
          if (tick) begin
            valid_d = match;
            out_d   = !match ? out_q + 1'b1 : mode_q == MODE_AUTO ? '0 :
                      mode_q == MODE_ONESHOT ? out_q : out_q + 1'b1;
            ovf_d   = ovf_q | (mode_q == MODE_FREE && &out_q);
            state_d = match && mode_q == MODE_ONESHOT ? ST_DONE : ST_RUN;
          end
        end
        default: if (!t_en) state_d = ST_IDLE;
      endcase
    end
    busy_d = state_d == ST_RUN || state_d == ST_PAUSE;
  end
  // state, configuration and registered outputs
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      presc_q <= '0;
      cmp_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  assign t_out   = out_q;
  assign t_valid = valid_q;
  assign t_busy  = busy_q;
  assign t_ovf   = ovf_q;
endmodule

// File: tb/tb_timer_param.sv
// tb_timer_param: vector table, directed corner sequences and random run against a tick-count model
module tb_timer_param;
  logic        clock = 1'b0, reset = 1'b0, t_en = 1'b0, t_clr = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  prescale = '0;
  logic [15:0] cmp_val = '0;
  logic [15:0] out16;
  logic [3:0]  out4;
  logic        v16, b16, o16, v4, b4, o4;
  int          pass_n = 0, tot_n = 0;
  bit          narrow = 0;
  bit          m_act, m_done, m_valid, m_ovf;
  longint      m_out, m_rc, m_p, m_cmp;
  int          m_mode;
  typedef struct {
    bit en; bit clr; logic [1:0] md; logic [7:0] p; logic [15:0] c;
    logic [15:0] out; bit v; bit b;
  } vec_t;
  vec_t tbl[$];

  timer_param dut16 (
    .clock(clock), .reset(reset), .t_en(t_en), .t_clr(t_clr), .mode(mode),
    .prescale(prescale), .cmp_val(cmp_val), .t_out(out16), .t_valid(v16),
    .t_busy(b16), .t_ovf(o16)
  );
  timer_param #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .t_en(t_en), .t_clr(t_clr), .mode(mode),
    .prescale(prescale), .cmp_val(cmp_val[3:0]), .t_out(out4), .t_valid(v4),
    .t_busy(b4), .t_ovf(o4)
  );

  always #5 clock = ~clock;

  initial begin
    #400us;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string n, input longint a, input longint e);
    tot_n++;
    if (a == e) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  task automatic m_reset();
    m_act = 0; m_done = 0; m_valid = 0; m_ovf = 0;
    m_out = 0; m_rc = 0; m_p = 0; m_cmp = 0; m_mode = 0;
  endtask

  // The model tracks enabled cycles since start; count, pulses and wrap follow from tick arithmetic.
  task automatic m_edge();
    longint m, t;
    m = narrow ? 16 : 65536;
    m_valid = 0;
    if (t_clr) begin
      m_act = 0; m_done = 0; m_out = 0; m_ovf = 0;
    end else if (m_done) begin
      if (!t_en) m_done = 0;
    end else if (!m_act) begin
      if (t_en) begin
        m_act = 1; m_rc = 0; m_p = prescale; m_out = 0;
        m_cmp = narrow ? longint'(cmp_val[3:0]) : longint'(cmp_val);
        m_mode = mode == 2'd3 ? 1 : int'(mode);
      end
    end else if (t_en) begin
      m_rc++;
      if (m_rc % (m_p + 1) == 0) begin
        t = m_rc / (m_p + 1);
        if (m_mode == 0) begin
          m_valid = ((t - 1) % m == m_cmp);
          m_out = t % m;
          if ((t - 1) % m == m - 1) m_ovf = 1;
        end else if (m_mode == 2) begin
          m_valid = (t % (m_cmp + 1) == 0);
          m_out = t % (m_cmp + 1);
        end else if (t == m_cmp + 1) begin
          m_valid = 1; m_done = 1; m_act = 0;
        end else m_out = t;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    m_edge();
    @(negedge clock);
  endtask

  task automatic cmp_all(input string n);
    chk({n, ".out"},   narrow ? longint'(out4) : longint'(out16), m_out);
    chk({n, ".valid"}, narrow ? v4 : v16, m_valid);
    chk({n, ".busy"},  narrow ? b4 : b16, m_act);
    chk({n, ".ovf"},   narrow ? o4 : o16, m_ovf);
  endtask

  task automatic clear();
    t_clr = 1; t_en = 0; cyc(); t_clr = 0;
  endtask

  task automatic setup(input logic [1:0] md, input logic [7:0] p, input logic [15:0] c);
    mode = md; prescale = p; cmp_val = c; t_en = 1; cyc();
  endtask

  initial begin
    int pulses, first, gap, n;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      t_en = ~t_en;
      #2;
      chk("reset.out", out16, 0);
      chk("reset.flags", {v16, b16, o16, v4, b4, o4}, 0);
    end
    @(negedge clock);
    reset = 1; t_en = 0;

    tbl.push_back('{1, 0, 2'd1, 8'd0, 16'd3, 16'd0, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 8'd5, 16'd9, 16'd1, 0, 1});
    tbl.push_back('{1, 0, 2'd2, 8'd5, 16'd9, 16'd2, 0, 1});
    tbl.push_back('{1, 0, 2'd1, 8'd0, 16'd3, 16'd3, 0, 1});
    tbl.push_back('{1, 0, 2'd1, 8'd0, 16'd3, 16'd3, 1, 0});
    tbl.push_back('{1, 0, 2'd1, 8'd0, 16'd3, 16'd3, 0, 0});
    tbl.push_back('{0, 0, 2'd1, 8'd0, 16'd3, 16'd3, 0, 0});
    tbl.push_back('{0, 0, 2'd2, 8'd7, 16'd1, 16'd3, 0, 0});
    tbl.push_back('{1, 1, 2'd3, 8'd0, 16'd1, 16'd0, 0, 0});
    tbl.push_back('{1, 0, 2'd3, 8'd0, 16'd1, 16'd0, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 8'd0, 16'd0, 16'd1, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 8'd0, 16'd0, 16'd1, 1, 0});
    foreach (tbl[i]) begin
      t_en = tbl[i].en; t_clr = tbl[i].clr; mode = tbl[i].md;
      prescale = tbl[i].p; cmp_val = tbl[i].c;
      cyc();
      chk($sformatf("vec%0d.out", i), out16, tbl[i].out);
      chk($sformatf("vec%0d.valid", i), v16, tbl[i].v);
      chk($sformatf("vec%0d.busy", i), b16, tbl[i].b);
    end
    t_clr = 0;
    clear();

    setup(2'd2, 8'd1, 16'd4);
    pulses = 0; first = -1; gap = 0;
    for (int i = 1; i <= 50; i++) begin
      mode = 2'd0; cmp_val = 16'd1;
      cyc();
      cmp_all("auto");
      if (v16) begin
        pulses++;
        if (first < 0) first = i; else if (gap == 0) gap = i - first;
      end
    end
    chk("auto.pulses", pulses, 5);
    chk("auto.period", gap, 10);
    clear();

    narrow = 1;
    clear();
    setup(2'd0, 8'd0, 16'd15);
    for (int i = 0; i < 20; i++) begin cyc(); cmp_all("free4"); end
    chk("free4.ovf_set", o4, 1);
    for (int i = 0; i < 20; i++) begin cyc(); cmp_all("free4s"); end
    chk("free4.ovf_sticky", o4, 1);
    clear();
    chk("free4.clr_out", out4, 0);
    chk("free4.clr_ovf", o4, 0);
    narrow = 0;

    setup(2'd2, 8'd2, 16'd9);
    n = 0;
    while (!v16 && n < 100) begin cyc(); cmp_all("pause.pre"); n++; end
    chk("pause.first_pulse", v16, 1);
    n = 0;
    while (out16 != 5 && n < 100) begin cyc(); cmp_all("pause.to5"); n++; end
    gap = n;
    t_en = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(); cmp_all("pause.hold");
      chk("pause.frozen", out16, 5);
    end
    t_en = 1;
    n = 0;
    while (!v16 && n < 100) begin cyc(); cmp_all("pause.post"); n++; end
    chk("pause.gap", gap + 7 + n, 37);
    clear();

    setup(2'd2, 8'd0, 16'd9);
    n = 0;
    while (out16 != 6 && n < 20) begin cyc(); n++; end
    chk("clr.at6", out16, 6);
    t_clr = 1;
    cyc();
    t_clr = 0;
    cmp_all("clr.mid");
    chk("clr.idle_busy", b16, 0);
    cyc();
    cmp_all("clr.restart");
    n = 0;
    while (out16 != 6 && n < 20) begin cyc(); n++; end
    chk("rst.at6", out16, 6);
    #2 reset = 0;
    #1;
    m_reset();
    cmp_all("rst.async");
    @(negedge clock);
    cmp_all("rst.hold");
    reset = 1; t_en = 0;
    cyc();
    cmp_all("rst.after");

    for (int ph = 0; ph < 2; ph++) begin
      narrow = ph[0];
      clear();
      for (int i = 0; i < 1500; i++) begin
        t_en = ($urandom % 8) != 0;
        t_clr = ($urandom % 64) == 0;
        mode = 2'($urandom % 4);
        prescale = 8'($urandom % 4);
        cmp_val = 16'($urandom % (narrow ? 16 : 8));
        cyc();
        cmp_all("rand");
      end
    end
    t_clr = 0;

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
